// File: rtl/left_right_piso_serializer.sv
// Parallel-in serial-out shifter with per-frame selectable bit order.
// Accepts one N-bit word in IDLE, then shifts it out one bit per enabled cycle.
module left_right_piso_serializer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] data_in,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic         left_right,
    input  logic         shift_en,
    output logic         serial_out,
    output logic         serial_valid,
    output logic         done,
    output logic         busy
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_reg;
    logic [N-1:0]    shreg_reg;
    logic            dir_reg;
    logic [CW-1:0]   count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            dir_reg   <= 1'b0;
            count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load_valid) begin
                        shreg_reg <= data_in;
                        dir_reg   <= left_right;
                        count_reg <= '0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        // Shift toward the output end so the next bit is always at the tap.
                        shreg_reg <= dir_reg ? {shreg_reg[N-2:0], 1'b0}
                                             : {1'b0, shreg_reg[N-1:1]};
                        if (count_reg == LAST) begin
                            count_reg <= '0;
                            state_reg <= IDLE;
                        end else begin
                            count_reg <= count_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only, so reset forces them without a clock.
    assign busy         = (state_reg == SHIFT);
    assign load_ready   = (state_reg == IDLE);
    assign serial_valid = busy && shift_en;
    assign serial_out   = busy && (dir_reg ? shreg_reg[N-1] : shreg_reg[0]);
    assign done         = serial_valid && (count_reg == LAST);

endmodule

// File: tb/tb_left_right_piso_serializer.sv
// Directed bench for left_right_piso_serializer (N=8): bit order, stalls,
// mid-frame load rejection, asynchronous reset and continuous loading.
module tb_left_right_piso_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       load_valid;
    logic       load_ready;
    logic       left_right;
    logic       shift_en;
    logic       serial_out;
    logic       serial_valid;
    logic       done;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;

    left_right_piso_serializer #(.N(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .left_right   (left_right),
        .shift_en     (shift_en),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .done         (done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_load_ready"},   load_ready,   1);
        check_eq({tag, "_busy"},         busy,         0);
        check_eq({tag, "_serial_valid"}, serial_valid, 0);
        check_eq({tag, "_serial_out"},   serial_out,   0);
        check_eq({tag, "_done"},         done,         0);
    endtask

    // exp_seq lists the expected serial bits in transfer order, first bit in [7].
    task automatic run_frame(input string tag, input logic [7:0] data, input logic dir,
                             input logic [7:0] exp_seq, input logic [15:0] stall_mask,
                             input logic inject, input int exp_done_cycle);
        int waited;
        int bit_idx;
        int dones;
        waited = 0;
        @(negedge clk);
        while (!load_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        check_eq({tag, "_ready_before"}, load_ready, 1);
        data_in    = data;
        left_right = dir;
        load_valid = 1'b1;
        shift_en   = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        bit_idx = 0;
        dones   = 0;
        for (int c = 1; bit_idx < 8; c++) begin
            if (c > 20) begin
                check_eq({tag, "_frame_timeout"}, bit_idx, 8);
                break;
            end
            shift_en = !stall_mask[c];
            if (inject && c >= 2) begin
                load_valid = 1'b1;
                data_in    = 8'hFF;
                left_right = ~dir;
            end
            @(negedge clk);
            check_eq($sformatf("%s_busy_c%0d", tag, c), busy, 1);
            check_eq($sformatf("%s_ready_c%0d", tag, c), load_ready, 0);
            check_eq($sformatf("%s_svalid_c%0d", tag, c), serial_valid, shift_en);
            check_eq($sformatf("%s_bit_c%0d", tag, c), serial_out, exp_seq[7 - bit_idx]);
            check_eq($sformatf("%s_done_c%0d", tag, c), done, (shift_en && bit_idx == 7));
            if (done) begin
                dones++;
                check_eq({tag, "_done_cycle"}, c, exp_done_cycle);
            end
            if (shift_en) bit_idx++;
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        shift_en   = 1'b1;
        @(negedge clk);
        check_idle_outputs({tag, "_after"});
        check_eq({tag, "_done_count"}, dones, 1);
        $display("[TB] frame %s data=0x%02h dir=%0d done_pulses=%0d", tag, data, dir, dones);
    endtask

    initial begin
        int accepts;
        int dones;
        int prev_accept;
        int bit_idx;
        logic [7:0] words [2];
        logic [7:0] exps  [2];
        logic [7:0] cur_exp;

        reset      = 1'b0;
        data_in    = 8'h00;
        load_valid = 1'b0;
        left_right = 1'b0;
        shift_en   = 1'b1;
        #1;
        check_idle_outputs("reset_initial");
        #21;
        reset = 1'b1;

        // MSB first, LSB first, stalled, and mid-frame load attempts.
        run_frame("msb_b4",   8'hB4, 1'b1, 8'b1011_0100, 16'h0000, 1'b0, 8);
        run_frame("lsb_b4",   8'hB4, 1'b0, 8'b0010_1101, 16'h0000, 1'b0, 8);
        run_frame("stall_b4", 8'hB4, 1'b1, 8'b1011_0100, 16'h0018, 1'b0, 10);
        run_frame("inject",   8'hB4, 1'b1, 8'b1011_0100, 16'h0000, 1'b1, 8);

        // Asynchronous reset after four bits have gone out.
        @(negedge clk);
        check_eq("rst_ready_before", load_ready, 1);
        data_in    = 8'hB4;
        left_right = 1'b1;
        load_valid = 1'b1;
        shift_en   = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check_eq("rst_busy_pre", busy, 1);
        reset = 1'b0;
        #1;
        check_idle_outputs("rst_async");
        repeat (2) begin
            @(negedge clk);
            check_idle_outputs("rst_held");
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        run_frame("post_rst_01", 8'h01, 1'b0, 8'b1000_0000, 16'h0000, 1'b0, 8);

        // load_valid held high: one accept every 9 cycles, alternating words.
        words[0] = 8'hA5; exps[0] = 8'b1010_0101;
        words[1] = 8'h3C; exps[1] = 8'b0011_1100;
        accepts     = 0;
        dones       = 0;
        prev_accept = -1;
        bit_idx     = 0;
        cur_exp     = 8'h00;
        left_right  = 1'b1;
        shift_en    = 1'b1;
        load_valid  = 1'b1;
        for (int cyc = 0; cyc < 45; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (load_ready) begin
                if (prev_accept >= 0)
                    check_eq($sformatf("cont_spacing_%0d", accepts), cyc - prev_accept, 9);
                prev_accept = cyc;
                data_in = words[accepts % 2];
                cur_exp = exps[accepts % 2];
                accepts++;
                bit_idx = 0;
            end else begin
                check_eq($sformatf("cont_bit_c%0d", cyc), serial_out, cur_exp[7 - bit_idx]);
                check_eq($sformatf("cont_done_c%0d", cyc), done, (bit_idx == 7));
                if (done) dones++;
                bit_idx++;
            end
        end
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        check_eq("cont_accepts", accepts, 5);
        check_eq("cont_dones", dones, 5);
        $display("[TB] continuous load: accepts=%0d done_pulses=%0d", accepts, dones);
        @(negedge clk);
        check_idle_outputs("cont_after");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
